// File: rtl/mem_stage_handshake.sv
// MIPS memory stage: EX/MEM register, sub-word load extraction and store lane steering,
// with valid/ready to EX/WB, a req/ack data-memory port, misalignment trap and ack timeout.
module mem_stage_handshake #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                REG_W    = 5,
    parameter int                PASS_W   = 2,
    parameter logic [PASS_W-1:0] PASS_RST = PASS_W'(2'b01),
    parameter int                TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_skip_ram,
    input  logic                  in_signed,
    input  logic [1:0]            in_size,
    input  logic                  in_re,
    input  logic                  in_we,
    input  logic [PASS_W-1:0]     in_pass,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [ADDR_W-1:0]     in_pc_seq,
    input  logic [REG_W-1:0]      in_write_reg,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [ADDR_W-1:0]     out_pc_seq,
    output logic [REG_W-1:0]      out_write_reg,
    output logic [PASS_W-1:0]     out_pass,
    output logic                  out_misalign,
    output logic                  out_timeout
);

    localparam int LANES = DATA_W / 8;
    localparam int LW    = $clog2(LANES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic                skip_q, skip_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [REG_W-1:0]    wreg_q, wreg_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                misalign_q, misalign_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                in_mem;
    logic                in_misaligned;
    logic [LW-1:0]       lane;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_ext;
    logic [LANES-1:0]    be_base;
    logic [CNT_W-1:0]    cnt_inc;

    assign in_mem  = in_re | in_we;
    assign lane    = addr_q[LW-1:0];
    assign cnt_inc = cnt_q + 1'b1;

    // A doubleword access can never be aligned on a 32-bit data path.
    always_comb begin
        case (in_size)
            2'd0:    in_misaligned = 1'b0;
            2'd1:    in_misaligned = in_addr[0];
            2'd2:    in_misaligned = |in_addr[1:0];
            default: in_misaligned = (DATA_W == 32) || (|in_addr[2:0]);
        endcase
    end

    always_comb begin
        shifted  = mem_rdata >> {lane, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'd0: load_ext = signed_q ? DATA_W'($signed(shifted[7:0]))
                                      : DATA_W'(shifted[7:0]);
            2'd1: load_ext = signed_q ? DATA_W'($signed(shifted[15:0]))
                                      : DATA_W'(shifted[15:0]);
            2'd2: load_ext = signed_q ? DATA_W'($signed(shifted[31:0]))
                                      : DATA_W'(shifted[31:0]);
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    be_base = LANES'(1);
            2'd1:    be_base = LANES'(3);
            2'd2:    be_base = LANES'(15);
            default: be_base = {LANES{1'b1}};
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    mem_wdata = {LANES{wdata_q[7:0]}};
            2'd1:    mem_wdata = {(LANES / 2){wdata_q[15:0]}};
            2'd2:    mem_wdata = {(LANES / 4){wdata_q[31:0]}};
            default: mem_wdata = wdata_q;
        endcase
    end

    assign mem_req  = (state_q == ACCESS);
    assign mem_we   = we_q;
    assign mem_addr = {addr_q[ADDR_W-1:LW], {LW{1'b0}}};
    assign mem_be   = be_base << lane;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        signed_d   = signed_q;
        skip_d     = skip_q;
        we_d       = we_q;
        pc_d       = pc_q;
        pass_d     = pass_q;
        wreg_d     = wreg_q;
        result_d   = result_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d     = in_addr;
                    wdata_d    = in_wdata;
                    size_d     = in_size;
                    signed_d   = in_signed;
                    skip_d     = in_skip_ram;
                    we_d       = in_we;
                    pc_d       = in_pc_seq;
                    pass_d     = in_pass;
                    wreg_d     = in_write_reg;
                    misalign_d = 1'b0;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                    result_d   = in_skip_ram ? DATA_W'(in_addr) : '0;
                    if (in_mem && in_misaligned) begin
                        misalign_d = 1'b1;
                        result_d   = '0;
                        wreg_d     = '0;
                        state_d    = DONE;
                    end else if (in_mem) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                // An ack arriving on the last allowed cycle still completes the access.
                if (mem_ack) begin
                    if (!we_q && !skip_q) begin
                        result_d = load_ext;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        timeout_d = 1'b1;
                        result_d  = '0;
                        wreg_d    = '0;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            skip_q     <= 1'b0;
            we_q       <= 1'b0;
            pc_q       <= '0;
            pass_q     <= PASS_RST;
            wreg_q     <= '0;
            result_q   <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            skip_q     <= skip_d;
            we_q       <= we_d;
            pc_q       <= pc_d;
            pass_q     <= pass_d;
            wreg_q     <= wreg_d;
            result_q   <= result_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign out_result    = result_q;
    assign out_pc_seq    = pc_q;
    assign out_write_reg = wreg_q;
    assign out_pass      = pass_q;
    assign out_misalign  = misalign_q;
    assign out_timeout   = timeout_q;

endmodule
